line_fill_unit: RTL

Refill engine between the cache controller and main memory. On a cache miss it issues one line-aligned read request to main memory and collects the 512-bit line as 16 sequential 32-bit beats. It then presents the assembled line to cache_mem for a single-cycle write. This replaces the single-cycle 512-bit main_mem path with a narrow, multi-cycle, handshaked memory bus.

---
 rtl/cache_pkg.sv | 23 ++
 rtl/line_fill_unit_line_buffer.sv | 31 +++
 rtl/line_fill_unit.sv | 133 +++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared types, constants and helpers for the cache refill path.
package cache_pkg;

    localparam int ADDR_W   = 32;
    localparam int BEAT_W   = 32;
    localparam int LINE_W   = 512;
    localparam int NBEATS   = LINE_W / BEAT_W;
    localparam int OFFSET_W = 6;
    localparam int TIMEOUT  = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        BURST = 2'd2,
        FILL  = 2'd3
    } fill_state_t;

    // Clear the byte-offset bits so the address points at the start of its line.
    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/line_fill_unit_line_buffer.sv
// Line assembly register: collects one cache line as indexed beat writes.
module line_buffer #(
    parameter int BEAT_W = 32,
    parameter int NBEATS = 16,
    parameter int IDX_W  = $clog2(NBEATS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic [IDX_W-1:0]         wr_idx,
    input  logic [BEAT_W-1:0]        wr_data,
    output logic [BEAT_W*NBEATS-1:0] line
);

    // Clear on reset or at the start of a burst, otherwise drop the beat into its slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line <= '0;
        end else if (clr) begin
            line <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NBEATS; i++) begin
                if (wr_idx == IDX_W'(i)) begin
                    line[i*BEAT_W +: BEAT_W] <= wr_data;
                end
            end
        end
    end

endmodule

// File: rtl/line_fill_unit.sv
// Refill engine: one line-aligned read request, 16 beats collected, one-cycle fill to cache_mem.
module line_fill_unit #(
    parameter int ADDR_W  = cache_pkg::ADDR_W,
    parameter int BEAT_W  = cache_pkg::BEAT_W,
    parameter int LINE_W  = cache_pkg::LINE_W,
    parameter int TIMEOUT = cache_pkg::TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_valid,
    input  logic [ADDR_W-1:0] miss_addr,
    output logic              miss_ready,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_rdata_valid,
    input  logic [BEAT_W-1:0] mem_rdata,
    output logic              fill_valid,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [LINE_W-1:0] fill_data,
    output logic              busy,
    output logic              err
);

    import cache_pkg::*;

    localparam int                BEATS     = LINE_W / BEAT_W;
    localparam int                IDX_W     = $clog2(BEATS);
    localparam logic [IDX_W-1:0]  LAST_BEAT = IDX_W'(BEATS - 1);
    localparam logic [7:0]        TMO_MAX   = 8'(TIMEOUT);

    fill_state_t       state_q;
    fill_state_t       state_d;
    logic [ADDR_W-1:0] line_addr_q;
    logic [IDX_W-1:0]  beat_cnt;
    logic [7:0]        tmo_cnt;
    logic [LINE_W-1:0] fill_data_q;
    logic [ADDR_W-1:0] fill_addr_q;
    logic [LINE_W-1:0] buf_line;
    logic              req_accept;
    logic              beat_fire;
    logic              timeout_hit;

    assign req_accept  = (state_q == REQ) && mem_req_ready;
    assign beat_fire   = (state_q == BURST) && mem_rdata_valid;
    assign timeout_hit = (state_q == BURST) && !mem_rdata_valid && (tmo_cnt == TMO_MAX);

    line_buffer #(
        .BEAT_W (BEAT_W),
        .NBEATS (BEATS),
        .IDX_W  (IDX_W)
    ) u_line_buffer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (req_accept),
        .wr_en   (beat_fire),
        .wr_idx  (beat_cnt),
        .wr_data (mem_rdata),
        .line    (buf_line)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: accept miss, wait for request handshake, count beats or time out.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (miss_valid) state_d = REQ;
            REQ:   if (mem_req_ready) state_d = BURST;
            BURST: begin
                if (beat_fire && (beat_cnt == LAST_BEAT)) begin
                    state_d = FILL;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            FILL:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Miss address capture, beat/idle counters and the held copy of the last fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_addr_q <= '0;
            beat_cnt    <= '0;
            tmo_cnt     <= '0;
            fill_data_q <= '0;
            fill_addr_q <= '0;
        end else begin
            if ((state_q == IDLE) && miss_valid) begin
                line_addr_q <= line_align(miss_addr);
            end
            if (req_accept) begin
                beat_cnt <= '0;
                tmo_cnt  <= '0;
            end else if (state_q == BURST) begin
                if (mem_rdata_valid) begin
                    if (beat_cnt != LAST_BEAT) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                    tmo_cnt <= '0;
                end else if (tmo_cnt != TMO_MAX) begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                end
            end
            if (state_q == FILL) begin
                fill_data_q <= buf_line;
                fill_addr_q <= line_addr_q;
            end
        end
    end

    // Outputs: the fill bus shows the live line during FILL and the held copy afterwards.
    always_comb begin
        miss_ready    = (state_q == IDLE);
        busy          = (state_q != IDLE);
        mem_req_valid = (state_q == REQ);
        mem_req_addr  = (state_q == REQ) ? line_addr_q : '0;
        fill_valid    = (state_q == FILL);
        fill_addr     = (state_q == FILL) ? line_addr_q : fill_addr_q;
        fill_data     = (state_q == FILL) ? buf_line : fill_data_q;
        err           = timeout_hit;
    end

endmodule
